hdmi_burst_reader: RTL
======================

HDMI_BURST_READER -- requirements
Module: hdmi_burst_reader

Interface
REQ-001 Parameter BURST_WORDS, default 64, words per DDR read burst (half pixel FIFO); legal range 1..1023.
REQ-002 Parameter DW, default 32, data word width in bits; byte length per burst = BURST_WORDS*DW/8.
REQ-003 Bus2IP_Clk  in  1  sole clock; all logic on rising edge.
REQ-004 Bus2IP_Resetn  in  1  reset, asynchronous assert, active-low.
REQ-005 go_fill_fifo  in  1  one-cycle burst request from fill FSM.
REQ-006 ddr_addr_to_read  in  32  burst start byte address, valid in the go_fill_fifo cycle.
REQ-007 IP2Bus_MstRd_Req  out  1  read command request to bus master.
REQ-008 IP2Bus_Mst_Addr  out  32  command byte address.
REQ-009 IP2Bus_Mst_Length  out  12  command byte length.
REQ-010 Bus2IP_Mst_CmdAck  in  1  command accepted.
REQ-011 Bus2IP_MstRd_d  in  DW  read data.
REQ-012 Bus2IP_MstRd_src_rdy_n  in  1  read data valid, active-low.
REQ-013 IP2Bus_MstRd_dst_rdy_n  out  1  ready to accept data, active-low.
REQ-014 Bus2IP_Mst_Cmplt  in  1  command complete pulse.
REQ-015 Bus2IP_Mst_Error  in  1  error qualifier, sampled with Cmplt.
REQ-016 fifo_full  in  1  pixel FIFO full.
REQ-017 fifo_wr_en  out  1  pixel FIFO write strobe.
REQ-018 fifo_din  out  DW  pixel FIFO write data.
REQ-019 busy  out  1  high in any state except IDLE or when a request is pending.
REQ-020 overrun  out  1  sticky: go_fill_fifo dropped.
REQ-021 rd_error  out  1  sticky: a burst completed with error.

Function
REQ-022 FSM states IDLE, REQ, XFER, CMPLT; IDLE->REQ on go_fill_fifo or pending valid.
REQ-023 On entering REQ, address is latched into IP2Bus_Mst_Addr (from ddr_addr_to_read if direct, else from pending register); Length = BURST_WORDS*DW/8.
REQ-024 REQ: IP2Bus_MstRd_Req high, Addr/Length stable, until the cycle Bus2IP_Mst_CmdAck=1; next state XFER; Req low the cycle after ack.
REQ-025 XFER: IP2Bus_MstRd_dst_rdy_n = fifo_full (combinational); a word is accepted in a cycle when src_rdy_n=0 and dst_rdy_n=0.
REQ-026 Each accepted word: fifo_wr_en=1 and fifo_din=Bus2IP_MstRd_d in the same cycle (zero latency); word counter (10 bits) increments.
REQ-027 No fifo_wr_en in any cycle where fifo_full=1 or outside XFER.
REQ-028 After BURST_WORDS-th accepted word: -> CMPLT; dst_rdy_n=1 outside XFER.
REQ-029 CMPLT: wait for Bus2IP_Mst_Cmplt; if Cmplt arrives during XFER it is latched and CMPLT exits in its first cycle; exit to REQ if pending valid, else IDLE.
REQ-030 Bus2IP_Mst_Error=1 with Cmplt sets rd_error; burst is not retried.
REQ-031 One-deep pending register: go_fill_fifo while not IDLE stores address and sets pending; pending clears when consumed on entry to REQ.
REQ-032 go_fill_fifo while pending already set: new request discarded, stored address kept, overrun set.
REQ-033 go_fill_fifo in the same cycle pending is consumed: new request stored (not overrun).
REQ-034 Word counter clears on entry to REQ.
REQ-035 overrun and rd_error clear only by reset.

Reset
REQ-036 Bus2IP_Resetn=0 immediately forces: state IDLE, Req=0, Addr=0, Length=0, dst_rdy_n=1, fifo_wr_en=0, fifo_din=0, pending=0, counter=0, busy=0, overrun=0, rd_error=0.
REQ-037 Reset mid-burst abandons the burst; no further fifo writes until a new go_fill_fifo after release.

Verification
REQ-038 go with addr 0x1000_0000, CmdAck after 3 cycles -> Req high 3 cycles, Addr 0x1000_0000, Length 0x100; 64 words written in order; Cmplt -> IDLE, busy=0.
REQ-039 fifo_full held high 5 cycles mid-burst, src_rdy_n held low -> dst_rdy_n=1 and no fifo_wr_en those cycles; total writes still exactly 64.
REQ-040 go at 0x100 during XFER of 0x0 -> after Cmplt, second Req issued with Addr 0x100 without returning to IDLE.
REQ-041 Three gos during one burst (0x100, 0x200, 0x300) -> overrun=1, next burst Addr 0x100, 0x200/0x300 never issued.
REQ-042 Cmplt with Error=1 -> rd_error=1 sticky across subsequent clean bursts.
REQ-043 Resetn low after 20 words -> all outputs at reset values same cycle; post-release go at 0x400 -> clean 64-word burst from 0x400.

Source files
------------

// File: rtl/hdmi_burst_reader_if.sv
// Read-side bus-master handshake between the HDMI burst reader and the IPIF master.
// The reader owns the command and destination-ready signals; the bus side owns the rest.
interface hdmi_burst_reader_if #(
  parameter int DW = 32
);
  logic          IP2Bus_MstRd_Req;
  logic [31:0]   IP2Bus_Mst_Addr;
  logic [11:0]   IP2Bus_Mst_Length;
  logic          Bus2IP_Mst_CmdAck;
  logic [DW-1:0] Bus2IP_MstRd_d;
  logic          Bus2IP_MstRd_src_rdy_n;
  logic          IP2Bus_MstRd_dst_rdy_n;
  logic          Bus2IP_Mst_Cmplt;
  logic          Bus2IP_Mst_Error;

  modport master (
    output IP2Bus_MstRd_Req, IP2Bus_Mst_Addr, IP2Bus_Mst_Length, IP2Bus_MstRd_dst_rdy_n,
    input  Bus2IP_Mst_CmdAck, Bus2IP_MstRd_d, Bus2IP_MstRd_src_rdy_n,
           Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error
  );

  modport slave (
    input  IP2Bus_MstRd_Req, IP2Bus_Mst_Addr, IP2Bus_Mst_Length, IP2Bus_MstRd_dst_rdy_n,
    output Bus2IP_Mst_CmdAck, Bus2IP_MstRd_d, Bus2IP_MstRd_src_rdy_n,
           Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error
  );
endinterface

// File: rtl/hdmi_burst_reader.sv
// Issues fixed-length DDR read bursts on request and streams the returned words straight
// into the pixel FIFO, with a one-deep queue for requests that arrive mid-burst.
module hdmi_burst_reader #(
  parameter int BURST_WORDS = 64,
  parameter int DW          = 32
) (
  input  logic                   Bus2IP_Clk,
  input  logic                   Bus2IP_Resetn,
  hdmi_burst_reader_if.master    bus,
  input  logic                   go_fill_fifo,
  input  logic [31:0]            ddr_addr_to_read,
  input  logic                   fifo_full,
  output logic                   fifo_wr_en,
  output logic [DW-1:0]          fifo_din,
  output logic                   busy,
  output logic                   overrun,
  output logic                   rd_error
);
  localparam logic [11:0] LEN  = 12'(BURST_WORDS * DW / 8);
  localparam logic [9:0]  LAST = 10'(BURST_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_CMPLT} state_t;

  state_t      r_state;
  logic        r_req;
  logic [31:0] r_addr;
  logic [11:0] r_len;
  logic        r_pend;
  logic [31:0] r_pend_addr;
  logic [9:0]  r_cnt;
  logic        r_cmplt_seen;
  logic        r_overrun;
  logic        r_rd_error;

  logic w_accept;
  logic w_cmplt_exit;
  logic w_consume;
  logic w_direct;
  logic w_err;

  assign w_accept     = (r_state == S_XFER) & ~bus.Bus2IP_MstRd_src_rdy_n & ~fifo_full;
  assign w_cmplt_exit = (r_state == S_CMPLT) & (r_cmplt_seen | bus.Bus2IP_Mst_Cmplt);
  assign w_consume    = r_pend & ((r_state == S_IDLE) | w_cmplt_exit);
  // A go seen in IDLE with nothing queued goes straight to the command, bypassing the queue.
  assign w_direct     = go_fill_fifo & (r_state == S_IDLE) & ~r_pend;
  assign w_err        = bus.Bus2IP_Mst_Cmplt & bus.Bus2IP_Mst_Error &
                        ((r_state == S_XFER) | (r_state == S_CMPLT));

  assign bus.IP2Bus_MstRd_Req       = r_req;
  assign bus.IP2Bus_Mst_Addr        = r_addr;
  assign bus.IP2Bus_Mst_Length      = r_len;
  assign bus.IP2Bus_MstRd_dst_rdy_n = (r_state != S_XFER) | fifo_full;
  assign fifo_wr_en = w_accept;
  assign fifo_din   = w_accept ? bus.Bus2IP_MstRd_d : '0;
  assign busy       = (r_state != S_IDLE) | r_pend;
  assign overrun    = r_overrun;
  assign rd_error   = r_rd_error;

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      r_state      <= S_IDLE;
      r_req        <= 1'b0;
      r_addr       <= '0;
      r_len        <= '0;
      r_pend       <= 1'b0;
      r_pend_addr  <= '0;
      r_cnt        <= '0;
      r_cmplt_seen <= 1'b0;
      r_overrun    <= 1'b0;
      r_rd_error   <= 1'b0;
    end else begin
      if (w_err) r_rd_error <= 1'b1;

      // The queue slot frees in the same cycle it is consumed, so a go then is kept.
      if (go_fill_fifo && !w_direct) begin
        if (!r_pend || w_consume) begin
          r_pend      <= 1'b1;
          r_pend_addr <= ddr_addr_to_read;
        end else begin
          r_overrun   <= 1'b1;
        end
      end else if (w_consume) begin
        r_pend <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (go_fill_fifo || r_pend) begin
            r_state      <= S_REQ;
            r_req        <= 1'b1;
            r_addr       <= r_pend ? r_pend_addr : ddr_addr_to_read;
            r_len        <= LEN;
            r_cnt        <= '0;
            r_cmplt_seen <= 1'b0;
          end
        end
        S_REQ: begin
          if (bus.Bus2IP_Mst_CmdAck) begin
            r_req   <= 1'b0;
            r_state <= S_XFER;
          end
        end
        S_XFER: begin
          if (bus.Bus2IP_Mst_Cmplt) r_cmplt_seen <= 1'b1;
          if (w_accept) begin
            r_cnt <= r_cnt + 10'd1;
            if (r_cnt == LAST) r_state <= S_CMPLT;
          end
        end
        S_CMPLT: begin
          if (w_cmplt_exit) begin
            r_cmplt_seen <= 1'b0;
            if (r_pend) begin
              r_state <= S_REQ;
              r_req   <= 1'b1;
              r_addr  <= r_pend_addr;
              r_len   <= LEN;
              r_cnt   <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
